msg_schedule: RTL and testbench



---
 rtl/msg_schedule.sv | 181 ++++++++++++++++++
 tb/tb_msg_schedule.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_schedule.sv
// ---------------------------------------------------------------------------
// msg_schedule
//
// Streaming SHA message-schedule generator. A 512-bit block is taken in
// through a valid/ready load handshake. The round words W[0..N-1] are then
// emitted one per accepted beat on a valid/ready output. Each block selects
// its own mode: SHA-1 expansion (N=80) or SHA-256 expansion (N=64).
//
// Parameters:
//   SHA256_EN  1 builds the SHA-256 expansion path. 0 removes it, and the
//              block is always treated as SHA-1.
//   WORD_W     word width. Must be 32.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   load_valid  a block is presented on block/mode
//   load_ready  a block can be accepted this cycle
//   mode        0=SHA-1, 1=SHA-256, captured together with the block
//   block       message block, W[0] in bits [511:480]
//   abort       drop the current block and return to idle
//   w_valid     w holds a valid round word
//   w_ready     consumer accepts w
//   w           current round word (always the oldest schedule word)
//   round       index of the word on w
//   last        w is the final word of the block
// ---------------------------------------------------------------------------
module msg_schedule #(
  parameter int SHA256_EN = 1,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              mode,
  input  logic [511:0]      block,
  input  logic              abort,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w,
  output logic [6:0]        round,
  output logic              last
);

  // The schedule window and every tap offset assume 32-bit words.
  if (WORD_W != 32) begin : gBadWordW
    $error("msg_schedule: WORD_W must be 32");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // SHA-256 small sigma functions.
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  state_t        r_state;
  logic [511:0]  r_sched;
  logic          r_modeQ;
  logic [6:0]    r_round;

  state_t        w_stateNext;
  logic          w_doLoad;
  logic          w_doShift;
  logic          w_clrRound;
  logic          w_beat;
  logic          w_isLast;
  logic [6:0]    w_lastIdx;
  logic          w_modeIn;
  logic [31:0]   w_sha1Mix;
  logic [31:0]   w_sha1Word;
  logic [31:0]   w_sha256Word;
  logic [WORD_W-1:0] w_nextWord;

  // With the SHA-256 path removed the captured mode is pinned to SHA-1,
  // so the adder tree and the 64-word length decode both fall away.
  if (SHA256_EN != 0) begin : gSha256
    assign w_modeIn     = mode;
    assign w_sha256Word = sigma1(r_sched[63:32]) + r_sched[223:192]
                        + sigma0(r_sched[479:448]) + r_sched[511:480];
  end else begin : gNoSha256
    assign w_modeIn     = 1'b0;
    assign w_sha256Word = '0;
  end

  // SHA-1 next word: W[i-3] ^ W[i-8] ^ W[i-14] ^ W[i-16], rotated left by 1.
  assign w_sha1Mix  = r_sched[95:64] ^ r_sched[255:224]
                    ^ r_sched[447:416] ^ r_sched[511:480];
  assign w_sha1Word = {w_sha1Mix[30:0], w_sha1Mix[31]};
  assign w_nextWord = r_modeQ ? w_sha256Word : w_sha1Word;

  assign w_lastIdx = r_modeQ ? 7'd63 : 7'd79;
  assign w_valid   = (r_state == RUN);
  assign w_beat    = w_valid & w_ready;
  assign w_isLast  = w_valid & (r_round == w_lastIdx);
  assign last      = w_isLast;
  assign w         = r_sched[511:480];
  assign round     = r_round;

  // The final beat reopens the load port so the next block can follow with
  // no bubble. abort masks this because an aborted cycle never loads.
  assign load_ready = (r_state == IDLE) | (w_beat & w_isLast & ~abort);

  // Next-state and datapath control. abort has priority over both the
  // beat and a reload. The final beat either reloads or drops to IDLE,
  // so round never wraps.
  always_comb begin
    w_stateNext = r_state;
    w_doLoad    = 1'b0;
    w_doShift   = 1'b0;
    w_clrRound  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_doLoad    = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_stateNext = IDLE;
          w_clrRound  = 1'b1;
        end else if (w_beat) begin
          if (w_isLast) begin
            if (load_valid) begin
              w_doLoad = 1'b1;
            end else begin
              w_doShift   = 1'b1;
              w_clrRound  = 1'b1;
              w_stateNext = IDLE;
            end
          end else begin
            w_doShift = 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Schedule window, captured mode and round counter. The window is left
  // untouched by abort. Only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sched <= '0;
      r_modeQ <= 1'b0;
      r_round <= '0;
    end else if (w_doLoad) begin
      r_sched <= block;
      r_modeQ <= w_modeIn;
      r_round <= '0;
    end else begin
      if (w_doShift) begin
        r_sched <= {r_sched[479:0], w_nextWord};
      end
      if (w_clrRound) begin
        r_round <= '0;
      end else if (w_doShift) begin
        r_round <= r_round + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// ---------------------------------------------------------------------------
// tb_msg_schedule
//
// Directed bench for msg_schedule. The default build runs the SHA-1 and
// SHA-256 "abc" blocks, a stall, an abort, a reset in the middle of a block
// and a back-to-back reload. A second instance built with SHA256_EN=0
// receives a mode=1 block and must produce the SHA-1 sequence.
// ---------------------------------------------------------------------------
module tb_msg_schedule;

  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic         mode;
  logic [511:0] block;
  logic         abort;
  logic         w_ready;

  logic         load_ready;
  logic         w_valid;
  logic [31:0]  w;
  logic [6:0]   round;
  logic         last;

  logic         loadReadyB;
  logic         wValidB;
  logic [31:0]  wB;
  logic [6:0]   roundB;
  logic         lastB;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0]  goldSha1   [0:79];
  logic [31:0]  goldSha256 [0:79];
  logic [511:0] blockAbc;
  logic [511:0] blockSeq;

  msg_schedule #(.SHA256_EN(1), .WORD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .mode(mode), .block(block), .abort(abort), .w_valid(w_valid),
    .w_ready(w_ready), .w(w), .round(round), .last(last)
  );

  msg_schedule #(.SHA256_EN(0), .WORD_W(32)) dutSha1Only (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(loadReadyB),
    .mode(mode), .block(block), .abort(abort), .w_valid(wValidB),
    .w_ready(w_ready), .w(wB), .round(roundB), .last(lastB)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it and report any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] refRotr(input logic [31:0] x, input int n);
    refRotr = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] refS0(input logic [31:0] x);
    refS0 = refRotr(x, 7) ^ refRotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] refS1(input logic [31:0] x);
    refS1 = refRotr(x, 17) ^ refRotr(x, 19) ^ (x >> 10);
  endfunction

  // Textbook array-indexed expansion of a block, for both modes.
  task automatic computeGolden(input logic [511:0] blk);
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      goldSha1[i]   = blk[511 - 32*i -: 32];
      goldSha256[i] = blk[511 - 32*i -: 32];
    end
    for (int i = 16; i < 80; i++) begin
      t = goldSha1[i-3] ^ goldSha1[i-8] ^ goldSha1[i-14] ^ goldSha1[i-16];
      goldSha1[i] = (t << 1) | (t >> 31);
    end
    for (int i = 16; i < 80; i++) begin
      goldSha256[i] = refS1(goldSha256[i-2]) + goldSha256[i-7]
                    + refS0(goldSha256[i-15]) + goldSha256[i-16];
    end
  endtask

  // Present a block for one cycle. It is expected to be accepted.
  task automatic applyStimulus(input logic [511:0] blk, input logic m);
    block      = blk;
    mode       = m;
    load_valid = 1'b1;
    #1;
    checkOutput("load_ready_on_load", {31'b0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
  endtask

  // Check the word currently on the output of the default instance.
  task automatic checkWord(input int i, input logic m);
    logic [31:0] exp;
    int          lastIdx;
    exp     = m ? goldSha256[i] : goldSha1[i];
    lastIdx = m ? 63 : 79;
    checkOutput($sformatf("w_valid[%0d]", i), {31'b0, w_valid}, 32'd1);
    checkOutput($sformatf("w[%0d]", i), w, exp);
    checkOutput($sformatf("round[%0d]", i), {25'b0, round}, i);
    checkOutput($sformatf("last[%0d]", i), {31'b0, last}, (i == lastIdx) ? 32'd1 : 32'd0);
  endtask

  task automatic runWords(input int first, input int lastI, input logic m);
    for (int i = first; i <= lastI; i++) begin
      checkWord(i, m);
      step();
    end
  endtask

  // Main sequence of directed scenarios.
  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    mode       = 1'b0;
    block      = '0;
    abort      = 1'b0;
    w_ready    = 1'b1;

    blockAbc = {32'h61626380, 448'h0, 32'h00000018};
    for (int j = 0; j < 16; j++) begin
      blockSeq[511 - 32*j -: 32] = 32'h0F1E2D3C + j * 32'h11111111;
    end
    computeGolden(blockAbc);

    // Reset state.
    step();
    step();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_w_valid", {31'b0, w_valid}, 32'd0);
    checkOutput("rst_last", {31'b0, last}, 32'd0);
    checkOutput("rst_w", w, 32'd0);
    checkOutput("rst_round", {25'b0, round}, 32'd0);
    checkOutput("rst_load_ready", {31'b0, load_ready}, 32'd1);

    // SHA-1 "abc" block, consumer always ready.
    applyStimulus(blockAbc, 1'b0);
    for (int i = 0; i < 80; i++) begin
      checkWord(i, 1'b0);
      if (i == 0)  checkOutput("sha1_hand_w0", w, 32'h61626380);
      if (i == 7)  checkOutput("sha1_hand_w7", w, 32'h00000000);
      if (i == 15) checkOutput("sha1_hand_w15", w, 32'h00000018);
      if (i == 16) checkOutput("sha1_hand_w16", w, 32'hC2C4C700);
      step();
    end
    checkOutput("sha1_end_w_valid", {31'b0, w_valid}, 32'd0);
    checkOutput("sha1_end_load_ready", {31'b0, load_ready}, 32'd1);

    // SHA-256 "abc" block: exactly 64 beats.
    applyStimulus(blockAbc, 1'b1);
    for (int i = 0; i < 64; i++) begin
      checkWord(i, 1'b1);
      if (i == 16) checkOutput("sha256_hand_w16", w, 32'h61626380);
      if (i == 17) checkOutput("sha256_hand_w17", w, 32'h000F0000);
      step();
    end
    checkOutput("sha256_end_w_valid", {31'b0, w_valid}, 32'd0);

    // Stall at round 20. A load attempt mid-block is refused first.
    applyStimulus(blockAbc, 1'b0);
    runWords(0, 4, 1'b0);
    checkWord(5, 1'b0);
    block      = blockSeq;
    load_valid = 1'b1;
    #1;
    checkOutput("midblock_load_ready", {31'b0, load_ready}, 32'd0);
    step();
    load_valid = 1'b0;
    runWords(6, 19, 1'b0);
    checkWord(20, 1'b0);
    w_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checkWord(20, 1'b0);
    end
    w_ready = 1'b1;
    runWords(20, 79, 1'b0);
    checkOutput("stall_end_w_valid", {31'b0, w_valid}, 32'd0);

    // abort at round 30 together with a beat and a reload attempt.
    applyStimulus(blockAbc, 1'b0);
    runWords(0, 29, 1'b0);
    checkWord(30, 1'b0);
    abort      = 1'b1;
    load_valid = 1'b1;
    mode       = 1'b1;
    block      = blockSeq;
    #1;
    checkOutput("abort_load_ready_same", {31'b0, load_ready}, 32'd0);
    step();
    abort      = 1'b0;
    load_valid = 1'b0;
    checkOutput("abort_w_valid", {31'b0, w_valid}, 32'd0);
    checkOutput("abort_round", {25'b0, round}, 32'd0);
    checkOutput("abort_last", {31'b0, last}, 32'd0);
    checkOutput("abort_load_ready", {31'b0, load_ready}, 32'd1);
    checkOutput("abort_w_kept", w, goldSha1[30]);
    step();
    checkOutput("abort_stay_idle", {31'b0, w_valid}, 32'd0);

    // Reset in the middle of a block.
    applyStimulus(blockAbc, 1'b0);
    runWords(0, 9, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("midrst_w_valid", {31'b0, w_valid}, 32'd0);
    checkOutput("midrst_w", w, 32'd0);
    checkOutput("midrst_round", {25'b0, round}, 32'd0);
    checkOutput("midrst_last", {31'b0, last}, 32'd0);
    checkOutput("midrst_load_ready", {31'b0, load_ready}, 32'd1);

    // SHA256_EN=0 instance given mode=1 must produce the 80-word SHA-1 run.
    applyStimulus(blockAbc, 1'b1);
    for (int i = 0; i < 80; i++) begin
      checkOutput($sformatf("noSha256_w_valid[%0d]", i), {31'b0, wValidB}, 32'd1);
      checkOutput($sformatf("noSha256_w[%0d]", i), wB, goldSha1[i]);
      checkOutput($sformatf("noSha256_round[%0d]", i), {25'b0, roundB}, i);
      checkOutput($sformatf("noSha256_last[%0d]", i), {31'b0, lastB}, (i == 79) ? 32'd1 : 32'd0);
      step();
    end
    checkOutput("noSha256_end_w_valid", {31'b0, wValidB}, 32'd0);

    // Back-to-back: second block offered during the final beat of the first.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    applyStimulus(blockAbc, 1'b0);
    runWords(0, 78, 1'b0);
    checkWord(79, 1'b0);
    computeGolden(blockSeq);
    block      = blockSeq;
    mode       = 1'b1;
    load_valid = 1'b1;
    #1;
    checkOutput("b2b_load_ready", {31'b0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
    checkOutput("b2b_w0_hand", w, 32'h0F1E2D3C);
    runWords(0, 63, 1'b1);
    checkOutput("b2b_end_w_valid", {31'b0, w_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
